// File: rtl/fx_button_ctrl.sv
// Footswitch press classifier: short press steps the effect selector, long press toggles bypass.
// Consumes an already-debounced, clk-synchronous button level.
module fx_button_ctrl #(
    parameter int NUM_FX     = 4,
    parameter int SEL_W      = 2,
    parameter int LONG_TICKS = 19_000_000,
    parameter int CNT_W      = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             db_in,
    output logic [SEL_W-1:0] fx_sel,
    output logic             bypass,
    output logic             short_pulse,
    output logic             long_pulse,
    output logic             held
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD      = 2'd1,
        LONG_WAIT = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] FX_LAST  = SEL_W'(NUM_FX - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] fx_sel_q, fx_sel_d;
    logic             bypass_q, bypass_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             db_prev_q;

    // db_prev resets high so a button held through reset release is not a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fx_sel_q  <= '0;
            bypass_q  <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            db_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fx_sel_q  <= fx_sel_d;
            bypass_q  <= bypass_d;
            short_q   <= short_d;
            long_q    <= long_d;
            db_prev_q <= db_in;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fx_sel_d = fx_sel_q;
        bypass_d = bypass_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (db_in && !db_prev_q) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                // release is checked before the long threshold so it wins on a tie
                if (!db_in) begin
                    fx_sel_d = (fx_sel_q == FX_LAST) ? '0 : fx_sel_q + 1'b1;
                    short_d  = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    bypass_d = ~bypass_q;
                    long_d   = 1'b1;
                    state_d  = LONG_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG_WAIT: begin
                if (!db_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fx_sel      = fx_sel_q;
    assign bypass      = bypass_q;
    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign held        = (state_q != IDLE);

endmodule
